// File: rtl/bist_pkg.sv
// Shared BIST definitions: session FSM states and default polynomial,
// seed and golden signature used by both the pattern generator and the MISR.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ABORT   = 2'd3
    } state_t;

    localparam logic [7:0] DEF_POLY   = 8'h1D;
    localparam logic [7:0] DEF_SEED   = 8'h00;
    localparam logic [7:0] DEF_GOLDEN = 8'h00;

endpackage

// File: rtl/misr_step.sv
// One combinational Galois MISR step: shift, fold the MSB back through
// the feedback taps, then XOR in the parallel response word.
module misr_step #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = '0
) (
    input  logic [W-1:0] i_s,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_f
);

    logic [W-1:0] w_fb;

    assign w_fb = i_s[W-1] ? POLY : '0;
    assign o_f  = {i_s[W-2:0], 1'b0} ^ w_fb ^ i_d;

endmodule

// File: rtl/misr_compactor.sv
// BIST output response analyser: compacts CUT words into a MISR while
// RUNNING, then freezes the signature and registers a golden-compare verdict.
module misr_compactor
    import bist_pkg::*;
#(
    parameter int           W      = 8,
    parameter logic [W-1:0] POLY   = W'(DEF_POLY),
    parameter logic [W-1:0] SEED   = W'(DEF_SEED),
    parameter logic [W-1:0] GOLDEN = W'(DEF_GOLDEN),
    parameter int           CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          running,
    input  logic          bist_end,
    input  logic [W-1:0]  cut_out,
    output logic [W-1:0]  signature,
    output logic [CW-1:0] vec_count,
    output logic          done,
    output logic          pass,
    output logic          aborted
);

    state_t        r_state;
    logic [W-1:0]  r_sig;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          r_pass;
    logic          r_abort;

    state_t        w_state_nxt;
    logic [W-1:0]  w_sig_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_done_nxt;
    logic          w_pass_nxt;
    logic          w_abort_nxt;

    logic          w_in_session;
    logic [W-1:0]  w_base;
    logic [W-1:0]  w_f;
    logic [W-1:0]  w_nxt;
    logic [CW-1:0] w_cnt_inc;

    // Outside a session the step starts from SEED, so restarts never
    // inherit the previous signature.
    assign w_in_session = (r_state == ST_COMPACT);
    assign w_base       = w_in_session ? r_sig : SEED;
    assign w_nxt        = running ? w_f : r_sig;
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

    misr_step #(
        .W    (W),
        .POLY (POLY)
    ) u_step (
        .i_s (w_base),
        .i_d (cut_out),
        .o_f (w_f)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_abort_nxt = r_abort;
        unique case (r_state)
            ST_COMPACT: begin
                if (bist_end) begin
                    w_sig_nxt   = w_nxt;
                    w_cnt_nxt   = running ? w_cnt_inc : r_cnt;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_nxt == GOLDEN);
                    w_state_nxt = ST_DONE;
                end else if (running) begin
                    w_sig_nxt   = w_f;
                    w_cnt_nxt   = w_cnt_inc;
                end else begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = ST_ABORT;
                end
            end
            default: begin
                if (running) begin
                    w_sig_nxt   = w_f;
                    w_cnt_nxt   = CW'(1);
                    w_done_nxt  = bist_end;
                    w_pass_nxt  = bist_end && (w_f == GOLDEN);
                    w_abort_nxt = 1'b0;
                    w_state_nxt = bist_end ? ST_DONE : ST_COMPACT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign signature = r_sig;
    assign vec_count = r_cnt;
    assign done      = r_done;
    assign pass      = r_pass;
    assign aborted   = r_abort;

endmodule
